clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
- Single-clock timebase generator that sits directly upstream of the I/O demo/processing blocks.
- Derives the four slow rate signals CLK_1MHz, CLK_100kHz, CLK_10Hz and CLK_1Hz from the system clock CLK with a cascade of four counter stages.
- Each stage delivers a near-50% square level, which downstream blocks sample and edge-detect in the CLK domain.
- Each stage also delivers a one-CLK-cycle tick pulse, so consumers can skip edge detection.
- No generated clocks: all outputs are registered data signals in the CLK domain.

Parameters:
DIV0, 50, CLK cycles per stage-0 period (50 MHz -> 1 MHz); must be >= 2
DIV1, 10, stage-0 ticks per stage-1 period (1 MHz -> 100 kHz); >= 2
DIV2, 10000, stage-1 ticks per stage-2 period (100 kHz -> 10 Hz); >= 2
DIV3, 10, stage-2 ticks per stage-3 period (10 Hz -> 1 Hz); >= 2

Ports:
CLK          in   1  system clock, all logic on rising edge
RST          in   1  asynchronous, active-high reset
EN           in   1  count enable; low freezes the whole chain
SYNC         in   1  synchronous restart of the whole chain (phase alignment)
CLK_1MHz     out  1  stage-0 square level
CLK_100kHz   out  1  stage-1 square level
CLK_10Hz     out  1  stage-2 square level
CLK_1Hz      out  1  stage-3 square level
TICK_1MHz    out  1  one-cycle pulse per stage-0 period
TICK_100kHz  out  1  one-cycle pulse per stage-1 period
TICK_10Hz    out  1  one-cycle pulse per stage-2 period
TICK_1Hz     out  1  one-cycle pulse per stage-3 period

Behaviour:
Interface:
- One clock, CLK.
- Reset is asynchronous and active-high, port RST.

Reset:
- RST=1 clears counters cnt0..cnt3 and drives all eight outputs to 0, independent of CLK.
- RST asserted mid-period aborts the period; there is no partial completion.

Counter widths:
- Counter n is $clog2(DIVn) bits wide; no other arithmetic is used.

Enable chain (combinational):
- adv0 = EN.
- advN = adv(N-1) && (cnt(N-1) == DIV(N-1)-1).

Per-stage update on each CLK edge, with RST=0 and SYNC=0:
- If advN: cntN <= (cntN == DIVn-1) ? 0 : cntN+1.
- Otherwise cntN holds.
- TICKn <= advN && (cntN == DIVn-1). This is registered, so it is high in the cycle where cntN has just wrapped to 0.
- Square output n <= (cntN < DIVn/2), registered every cycle using integer division.
- High time is floor(DIVn/2) and low time is ceil(DIVn/2) stage-input periods; duty is exactly 50% for even DIVn.

EN=0:
- All counters and square outputs hold their values.
- All TICK outputs are 0 from the next edge.
- Resuming EN continues the phase without any skip.

SYNC=1 at an edge:
- Takes priority over EN.
- All counters <= 0; all outputs <= 0.
- After SYNC deasserts, the sequence is identical to the one after reset release.

Relationships between stages:
- Simultaneous wraps in several stages are normal: all affected TICKs pulse in the same cycle.
- TICK_1Hz implies TICK_10Hz, which implies TICK_100kHz, which implies TICK_1MHz.
- TICK period for stage n is DIV0 × … × DIVn CLK cycles, exactly, with no drift.

Latency:
- The first TICK_1MHz occurs after edge DIV0 following reset release with EN=1.
- The first CLK_1MHz high occurs after edge 1.

Test Plan:
Small parameters used throughout: DIV0=4, DIV1=3, DIV2=5, DIV3=2, EN=1; edge k is the k-th rising CLK edge after RST release.
1. Reset/stage 0:
   - Outputs all 0 during RST.
   - CLK_1MHz = 1,1,0,0 after edges 1..4 and repeating.
   - TICK_1MHz high only after edges 4, 8, 12, ….
2. Cascade:
   - TICK_100kHz after edges 12, 24.
   - TICK_10Hz after edge 60.
   - TICK_1Hz after edges 120, 240, coincident with all lower TICKs.
   - CLK_100kHz high after edges 1–4, low after edges 5–12.
3. EN low after edges 6..15 (10 cycles):
   - Counters and levels frozen, TICKs 0.
   - Next TICK_1MHz after edge 18, not 8.
   - TICK_100kHz after edge 22.
4. SYNC pulse at edge 7:
   - All outputs 0 after edge 7.
   - The post-reset pattern restarts: next TICK_1MHz after edge 11.
5. Async RST asserted mid-cycle at edge 50.5:
   - Outputs go to 0 immediately, with no CLK edge needed.
   - After release, test 1 repeats exactly.
6. Default parameters:
   - CLK_1MHz has period 50 with 25 cycles high.
   - Exactly 10 TICK_1MHz pulses per TICK_100kHz pulse.
   - TICK_100kHz spacing is 500 cycles.

Source files
------------

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: single-clock timebase. A cascade of four modulo counters
// produces near-50% square levels and one-cycle tick pulses, all as
// registered data signals in the CLK domain (no derived clocks).
module clk_tick_gen #(
    parameter int DIV0 = 50,
    parameter int DIV1 = 10,
    parameter int DIV2 = 10000,
    parameter int DIV3 = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic SYNC,
    output logic CLK_1MHz,
    output logic CLK_100kHz,
    output logic CLK_10Hz,
    output logic CLK_1Hz,
    output logic TICK_1MHz,
    output logic TICK_100kHz,
    output logic TICK_10Hz,
    output logic TICK_1Hz
);

    localparam int W0 = $clog2(DIV0);
    localparam int W1 = $clog2(DIV1);
    localparam int W2 = $clog2(DIV2);
    localparam int W3 = $clog2(DIV3);

    // Terminal counts and the high/low split point of each stage.
    localparam logic [W0-1:0] TOP0  = W0'(DIV0 - 1);
    localparam logic [W1-1:0] TOP1  = W1'(DIV1 - 1);
    localparam logic [W2-1:0] TOP2  = W2'(DIV2 - 1);
    localparam logic [W3-1:0] TOP3  = W3'(DIV3 - 1);
    localparam logic [W0-1:0] HALF0 = W0'(DIV0 / 2);
    localparam logic [W1-1:0] HALF1 = W1'(DIV1 / 2);
    localparam logic [W2-1:0] HALF2 = W2'(DIV2 / 2);
    localparam logic [W3-1:0] HALF3 = W3'(DIV3 / 2);

    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;
    logic [W2-1:0] cnt2;
    logic [W3-1:0] cnt3;

    logic wrap0, wrap1, wrap2, wrap3;
    logic adv0, adv1, adv2, adv3;

    // Enable chain: a stage advances only when every stage below it wraps.
    always_comb begin
        wrap0 = (cnt0 == TOP0);
        wrap1 = (cnt1 == TOP1);
        wrap2 = (cnt2 == TOP2);
        wrap3 = (cnt3 == TOP3);
        adv0  = EN;
        adv1  = adv0 && wrap0;
        adv2  = adv1 && wrap1;
        adv3  = adv2 && wrap2;
    end

    // Stage 0 counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       cnt0 <= '0;
        else if (SYNC) cnt0 <= '0;
        else if (adv0) cnt0 <= wrap0 ? '0 : cnt0 + 1'b1;
    end

    // Stage 1 counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       cnt1 <= '0;
        else if (SYNC) cnt1 <= '0;
        else if (adv1) cnt1 <= wrap1 ? '0 : cnt1 + 1'b1;
    end

    // Stage 2 counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       cnt2 <= '0;
        else if (SYNC) cnt2 <= '0;
        else if (adv2) cnt2 <= wrap2 ? '0 : cnt2 + 1'b1;
    end

    // Stage 3 counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       cnt3 <= '0;
        else if (SYNC) cnt3 <= '0;
        else if (adv3) cnt3 <= wrap3 ? '0 : cnt3 + 1'b1;
    end

    // Registered outputs. Ticks mark the cycle after a wrap; square levels
    // freeze with EN so that the output phase resumes without a skip.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || SYNC) begin
            TICK_1MHz   <= 1'b0;
            TICK_100kHz <= 1'b0;
            TICK_10Hz   <= 1'b0;
            TICK_1Hz    <= 1'b0;
            CLK_1MHz    <= 1'b0;
            CLK_100kHz  <= 1'b0;
            CLK_10Hz    <= 1'b0;
            CLK_1Hz     <= 1'b0;
        end else begin
            TICK_1MHz   <= adv0 && wrap0;
            TICK_100kHz <= adv1 && wrap1;
            TICK_10Hz   <= adv2 && wrap2;
            TICK_1Hz    <= adv3 && wrap3;
            if (EN) begin
                CLK_1MHz   <= (cnt0 < HALF0);
                CLK_100kHz <= (cnt1 < HALF1);
                CLK_10Hz   <= (cnt2 < HALF2);
                CLK_1Hz    <= (cnt3 < HALF3);
            end
        end
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: drives a small-divider instance and a default-divider
// instance with the same stimulus and checks both against a model that
// expresses every output as a function of the number of enabled edges
// since the last reset/restart.
module tb_clk_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic sync = 1'b0;

    logic [3:0] sq_s, tk_s, sq_d, tk_d;

    int checks = 0;
    int failures = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    clk_tick_gen #(.DIV0(4), .DIV1(3), .DIV2(5), .DIV3(2)) dut_s (
        .CLK(clk), .RST(rst), .EN(en), .SYNC(sync),
        .CLK_1MHz(sq_s[0]), .CLK_100kHz(sq_s[1]), .CLK_10Hz(sq_s[2]), .CLK_1Hz(sq_s[3]),
        .TICK_1MHz(tk_s[0]), .TICK_100kHz(tk_s[1]), .TICK_10Hz(tk_s[2]), .TICK_1Hz(tk_s[3])
    );

    clk_tick_gen dut_d (
        .CLK(clk), .RST(rst), .EN(en), .SYNC(sync),
        .CLK_1MHz(sq_d[0]), .CLK_100kHz(sq_d[1]), .CLK_10Hz(sq_d[2]), .CLK_1Hz(sq_d[3]),
        .TICK_1MHz(tk_d[0]), .TICK_100kHz(tk_d[1]), .TICK_10Hz(tk_d[2]), .TICK_1Hz(tk_d[3])
    );

    // ---------------- reference model ----------------
    // After the k-th enabled edge: stage n has seen floor((k-1)/Q) inputs
    // before that edge (Q = product of lower dividers), so its level is
    // ((k-1)/Q mod DIV) < DIV/2, and it ticks when k is a multiple of Q*DIV.
    int div_tab [2][4] = '{'{4, 3, 5, 2}, '{50, 10, 10000, 10}};
    int m_k = 0;
    logic [3:0] m_sq [2] = '{4'h0, 4'h0};
    logic [3:0] m_tk [2] = '{4'h0, 4'h0};

    always @(posedge clk or posedge rst) begin
        if (rst || sync) begin
            m_k = 0;
            for (int c = 0; c < 2; c++) begin
                m_sq[c] = 4'h0;
                m_tk[c] = 4'h0;
            end
        end else if (en) begin
            m_k = m_k + 1;
            for (int c = 0; c < 2; c++) begin
                int q;
                q = 1;
                for (int n = 0; n < 4; n++) begin
                    m_sq[c][n] = (((m_k - 1) / q) % div_tab[c][n]) < (div_tab[c][n] / 2);
                    m_tk[c][n] = (m_k % (q * div_tab[c][n])) == 0;
                    q = q * div_tab[c][n];
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) m_tk[c] = 4'h0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("model_sq_small", int'(sq_s), int'(m_sq[0]));
        chk("model_tk_small", int'(tk_s), int'(m_tk[0]));
        chk("model_sq_dflt", int'(sq_d), int'(m_sq[1]));
        chk("model_tk_dflt", int'(tk_d), int'(m_tk[1]));
    end

    // ---------------- driver tasks ----------------
    task automatic edge_go(input logic en_v, input logic sync_v);
        #1;
        en = en_v;
        sync = sync_v;
        @(negedge clk);
        edge_no++;
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        en = 1'b1;
        sync = 1'b0;
        @(negedge clk);
        chk("reset_outputs_small", int'({sq_s, tk_s}), 0);
        chk("reset_outputs_dflt", int'({sq_d, tk_d}), 0);
        #1;
        rst = 1'b0;
        edge_no = 0;
    endtask

    // Hand-computed expectations for DIV = 4,3,5,2 after reset, EN=1.
    task automatic stage_checks();
        logic [3:0] pat;
        pat = 4'b0011;  // CLK_1MHz after edges 1,2,3,4 = 1,1,0,0
        for (int e = 1; e <= 130; e++) begin
            edge_go(1'b1, 1'b0);
            chk("clk_1mhz_pattern", int'(sq_s[0]), int'(pat[(e - 1) % 4]));
            chk("tick_1mhz_spacing", int'(tk_s[0]), int'(e % 4 == 0));
            if (e == 11 || e == 12 || e == 24) chk("tick_100khz", int'(tk_s[1]), int'(e != 11));
            if (e == 59 || e == 60) chk("tick_10hz", int'(tk_s[2]), int'(e == 60));
            if (e == 119 || e == 120 || e == 240) chk("tick_1hz", int'(tk_s[3]), int'(e != 119));
            if (e == 120) chk("all_ticks_at_120", int'(tk_s), 15);
            if (e == 4 || e == 13) chk("clk_100khz_high", int'(sq_s[1]), 1);
            if (e == 5 || e == 12) chk("clk_100khz_low", int'(sq_s[1]), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    int last_t1;
    int t0_cnt;
    int hi_cnt;

    initial begin
        // Test 1/2: reset, stage 0 pattern, cascade.
        do_reset();
        stage_checks();

        // Test 3: EN low during edges 6..15.
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            edge_go((e < 6 || e > 15), 1'b0);
            if (e == 8)  chk("en_low_no_tick_8", int'(tk_s[0]), 0);
            if (e == 10) chk("en_low_level_held", int'(sq_s[0]), 1);
            if (e == 10) chk("en_low_ticks_zero", int'(tk_s), 0);
            if (e == 18) chk("en_resume_tick_18", int'(tk_s[0]), 1);
            if (e == 22) chk("en_resume_tick100k_22", int'(tk_s[1]), 1);
        end

        // Test 4: SYNC at edge 7.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            edge_go(1'b1, (e == 7));
            if (e == 7)  chk("sync_clears", int'({sq_s, tk_s}), 0);
            if (e == 8)  chk("sync_no_tick_8", int'(tk_s[0]), 0);
            if (e == 8)  chk("sync_restart_level", int'(sq_s[0]), 1);
            if (e == 11) chk("sync_tick_11", int'(tk_s[0]), 1);
        end

        // Test 5: asynchronous reset mid-cycle after edge 50, then repeat test 1.
        do_reset();
        for (int e = 1; e <= 50; e++) edge_go(1'b1, 1'b0);
        chk("pre_async_level", int'(sq_s[0]), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_small", int'({sq_s, tk_s}), 0);
        chk("async_reset_dflt", int'({sq_d, tk_d}), 0);
        do_reset();
        stage_checks();

        // Test 6: default dividers.
        do_reset();
        last_t1 = -1;
        t0_cnt = 0;
        hi_cnt = 0;
        for (int e = 1; e <= 1100; e++) begin
            edge_go(1'b1, 1'b0);
            if (e >= 101 && e <= 150 && sq_d[0]) hi_cnt++;
            if (tk_d[0]) t0_cnt++;
            if (tk_d[1]) begin
                if (last_t1 >= 0) begin
                    chk("dflt_tick100k_spacing", e - last_t1, 500);
                    chk("dflt_ticks_per_100k", t0_cnt, 10);
                end
                last_t1 = e;
                t0_cnt = 0;
            end
        end
        chk("dflt_clk_1mhz_high_time", hi_cnt, 25);
        chk("dflt_last_tick100k_edge", last_t1, 1000);

        // Randomized run: mostly enabled, occasional SYNC and async reset.
        for (int i = 0; i < 20000; i++) begin
            #1;
            rst = ($urandom_range(0, 999) == 0);
            en = ($urandom_range(0, 9) != 0);
            sync = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            edge_no++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
